lsu: RTL and testbench
======================

# lsu

Load/store unit between the execute stage and the data-memory port. Accepts one load or store request at a time from the pipeline, checks alignment and access size, drives the `mem_if` master side (word-aligned address, byte strobes, lane-shifted write data), waits for the memory's `s_ready`, then returns the sign- or zero-extended load data, or a store acknowledge, to writeback. It is the upstream master for every `mem_if.slave` data memory.

## Interface
- No parameters. Data and address width are fixed at 32 by `mem_if`.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: pipeline request valid.
- `req_ready` out 1: LSU can accept a request.
- `req_is_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I size/sign field. Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU. Stores: 0 SB, 1 SH, 2 SW.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `dmem` `mem_if.master`: `m_valid`, `m_addr`, `m_wdata`, `m_wstrb` out; `s_ready`, `s_rdata` in.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and faults.
- `resp_misaligned` out 1: address not naturally aligned for the access size.
- `resp_illegal` out 1: unsupported funct3 for the access type.

## Operation
- FSM `lsu_state_t`: IDLE, BUSY, RESP.
- IDLE: `req_ready`=1. On `req_valid`, the request is accepted and all request fields are registered.
  - Legal and aligned → BUSY.
  - Otherwise → RESP with the matching fault bit, and no memory access.
  - Illegal takes precedence over misaligned: `resp_illegal`=1, `resp_misaligned`=0.
- Alignment rules: halfword requires `addr[0]`=0; word requires `addr[1:0]`=0.
- Illegal funct3: loads 3, 6, 7; stores 3–7.
- BUSY:
  - `m_valid`=1, `m_addr`={addr[31:2],2'b00}.
  - Loads: `m_wstrb`=0.
  - Stores: SB strobe = 4'b0001<<addr[1:0]; SH strobe = 4'b0011<<addr[1:0]; SW strobe = 4'b1111.
  - `m_wdata`: the byte/half is replicated across all lanes (SB {4{b}}, SH {2{h}}, SW as is).
  - All `m_*` outputs stay stable until `s_ready`=1. In that cycle the LSU registers `s_rdata` (loads only) and moves to RESP.
- Load extraction:
  - byte = `s_rdata` lane addr[1:0]; half = lane addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE. `req_ready`=0 in BUSY and RESP.
- Reset values: state IDLE; `m_valid`, `resp_valid`, `resp_misaligned`, `resp_illegal` = 0; `m_addr`, `m_wdata`, `m_wstrb`, `resp_rdata` = 0.
- Reset mid-transaction (BUSY or RESP): FSM returns to IDLE next cycle, `m_valid` drops, no response is issued. The memory must tolerate an abandoned request.
- `resp_*` data/flag outputs are meaningful only while `resp_valid`=1 and read 0 otherwise.

## Timing
- Acceptance at edge N (IDLE, `req_valid`=1) → `m_valid`=1 in cycle N+1.
- Zero-wait memory (`s_ready`=1 in N+1) → `resp_valid` in N+2. Each wait cycle adds one.
- Faulted request → `resp_valid` in N+1, and `m_valid` is never asserted.
- Back-to-back throughput: next `req_ready` is in the cycle after `resp_valid`, giving a minimum of 3 cycles per access.
- `s_ready` is sampled only while `m_valid`=1. `s_ready` high in IDLE or RESP is ignored.
- No combinational path from `s_ready`/`s_rdata` to any output. All outputs are registered, except `req_ready`, which decodes only the state.

## Structure
- `core_pkg` holds:
  - funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the `lsu_state_t` enum;
  - a `mem_req_t` struct (is_store, funct3, addr, wdata) used for the registered request.
- One combinational sub-module, `lsu_align`: (funct3, addr[1:0], wdata, rdata) → (wstrb, lane_wdata, ext_rdata, misaligned, illegal). `lsu` keeps the FSM and registers.

## Test plan
- LW at 0x100, memory word 0xDEADBEEF, zero wait → `m_addr`=0x100, `m_wstrb`=0. `resp_rdata`=0xDEADBEEF two cycles after acceptance.
- LB at 0x103 and LBU at 0x103, word 0x80FF1234 → 0xFFFFFF80 and 0x00000080 respectively.
- SH at 0x202 with data 0x0000ABCD, three wait cycles → `m_wstrb`=4'b1100, `m_wdata`=0xABCDABCD. `m_*` held stable for 4 cycles; `resp_valid` 5 cycles after acceptance.
- LW at 0x101 → `resp_misaligned`=1 in N+1 with `m_valid` never high. Store with funct3=4 → `resp_illegal`=1.
- Reset asserted while BUSY with `s_ready`=0 → `m_valid`=0 and `req_ready`=1 the next cycle, and no `resp_valid` pulse.
- Three back-to-back SW/LW/LHU requests with random 0–3 wait states, checked against a reference memory model → all responses match, one per request, in order.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the load/store path: funct3 size codes,
// LSU state encoding and the registered request record.
package core_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  typedef struct packed {
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_if.sv
// Word-wide data-memory port: master drives the request, slave returns
// ready and read data.
interface mem_if;
  logic        m_valid;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;

  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb,
    input  s_ready, s_rdata
  );

  modport slave (
    input  m_valid, m_addr, m_wdata, m_wstrb,
    output s_ready, s_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational size/alignment decode: fault detection, store lane strobes and
// replicated write data, and load-lane extraction with sign/zero extension.
module lsu_align
  import core_pkg::*;
(
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_lane_wdata,
  output logic [31:0] o_ext_rdata,
  output logic        o_misaligned,
  output logic        o_illegal
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_raw_mis;

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_illegal = i_is_store ? (i_funct3 > F3_W)
                           : ((i_funct3 == 3'd3) || (i_funct3[2:1] == 2'b11));
    case (i_funct3[1:0])
      2'b01:   w_raw_mis = i_addr_lo[0];
      2'b10:   w_raw_mis = |i_addr_lo;
      default: w_raw_mis = 1'b0;
    endcase
    // Illegal wins, so a bad funct3 never also reports misalignment
    o_misaligned = w_raw_mis & ~o_illegal;
  end

  always_comb begin
    o_wstrb = 4'b0000;
    if (i_is_store && !o_illegal) begin
      case (i_funct3[1:0])
        2'b00:   o_wstrb = 4'b0001 << i_addr_lo;
        2'b01:   o_wstrb = 4'b0011 << i_addr_lo;
        2'b10:   o_wstrb = 4'b1111;
        default: o_wstrb = 4'b0000;
      endcase
    end
  end

  always_comb begin
    case (i_funct3[1:0])
      2'b00:   o_lane_wdata = {4{i_wdata[7:0]}};
      2'b01:   o_lane_wdata = {2{i_wdata[15:0]}};
      default: o_lane_wdata = i_wdata;
    endcase
  end

  always_comb begin
    case (i_funct3)
      F3_B:    o_ext_rdata = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_ext_rdata = {24'h0, w_byte};
      F3_H:    o_ext_rdata = {{16{w_half[15]}}, w_half};
      F3_HU:   o_ext_rdata = {16'h0, w_half};
      F3_W:    o_ext_rdata = i_rdata;
      default: o_ext_rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one pipeline request at a time, issues it on the
// data-memory port and returns a single-cycle registered response.
module lsu
  import core_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_is_store,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  mem_if.master       dmem,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_misaligned,
  output logic        o_resp_illegal
);

  lsu_state_t  r_state;
  mem_req_t    r_req;
  logic        r_m_valid;
  logic [31:0] r_m_wdata;
  logic [3:0]  r_m_wstrb;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_misaligned;
  logic        r_resp_illegal;

  mem_req_t    w_req_in;
  logic        w_sel_is_store;
  logic [2:0]  w_sel_funct3;
  logic [1:0]  w_sel_addr_lo;
  logic [31:0] w_sel_wdata;
  logic [3:0]  w_wstrb;
  logic [31:0] w_lane_wdata;
  logic [31:0] w_ext_rdata;
  logic        w_misaligned;
  logic        w_illegal;

  assign w_req_in = '{is_store: i_req_is_store, funct3: i_req_funct3,
                      addr: i_req_addr, wdata: i_req_wdata};

  // The decoder sees the incoming request while idle, the held one otherwise
  assign w_sel_is_store = (r_state == IDLE) ? w_req_in.is_store  : r_req.is_store;
  assign w_sel_funct3   = (r_state == IDLE) ? w_req_in.funct3    : r_req.funct3;
  assign w_sel_addr_lo  = (r_state == IDLE) ? w_req_in.addr[1:0] : r_req.addr[1:0];
  assign w_sel_wdata    = (r_state == IDLE) ? w_req_in.wdata     : r_req.wdata;

  lsu_align u_align (
    .i_is_store   (w_sel_is_store),
    .i_funct3     (w_sel_funct3),
    .i_addr_lo    (w_sel_addr_lo),
    .i_wdata      (w_sel_wdata),
    .i_rdata      (dmem.s_rdata),
    .o_wstrb      (w_wstrb),
    .o_lane_wdata (w_lane_wdata),
    .o_ext_rdata  (w_ext_rdata),
    .o_misaligned (w_misaligned),
    .o_illegal    (w_illegal)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state           <= IDLE;
      r_req             <= '0;
      r_m_valid         <= 1'b0;
      r_m_wdata         <= 32'h0;
      r_m_wstrb         <= 4'h0;
      r_resp_valid      <= 1'b0;
      r_resp_rdata      <= 32'h0;
      r_resp_misaligned <= 1'b0;
      r_resp_illegal    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_req <= w_req_in;
            if (w_illegal || w_misaligned) begin
              r_state           <= RESP;
              r_resp_valid      <= 1'b1;
              r_resp_rdata      <= 32'h0;
              r_resp_illegal    <= w_illegal;
              r_resp_misaligned <= w_misaligned;
            end else begin
              r_state   <= BUSY;
              r_m_valid <= 1'b1;
              r_m_wstrb <= w_wstrb;
              r_m_wdata <= w_lane_wdata;
            end
          end
        end
        BUSY: begin
          if (dmem.s_ready) begin
            r_state      <= RESP;
            r_m_valid    <= 1'b0;
            r_m_wstrb    <= 4'h0;
            r_m_wdata    <= 32'h0;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_req.is_store ? 32'h0 : w_ext_rdata;
          end
        end
        RESP: begin
          r_state           <= IDLE;
          r_resp_valid      <= 1'b0;
          r_resp_rdata      <= 32'h0;
          r_resp_misaligned <= 1'b0;
          r_resp_illegal    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_req_ready       = (r_state == IDLE);
  assign dmem.m_valid      = r_m_valid;
  assign dmem.m_addr       = {r_req.addr[31:2], 2'b00};
  assign dmem.m_wdata      = r_m_wdata;
  assign dmem.m_wstrb      = r_m_wstrb;
  assign o_resp_valid      = r_resp_valid;
  assign o_resp_rdata      = r_resp_rdata;
  assign o_resp_misaligned = r_resp_misaligned;
  assign o_resp_illegal    = r_resp_illegal;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized traffic
// against a byte-level reference memory.
module tb_lsu;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_misaligned, resp_illegal;
  logic [31:0] resp_rdata;

  mem_if dmem ();

  lsu dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_req_valid       (req_valid),
    .o_req_ready       (req_ready),
    .i_req_is_store    (req_is_store),
    .i_req_funct3      (req_funct3),
    .i_req_addr        (req_addr),
    .i_req_wdata       (req_wdata),
    .dmem              (dmem),
    .o_resp_valid      (resp_valid),
    .o_resp_rdata      (resp_rdata),
    .o_resp_misaligned (resp_misaligned),
    .o_resp_illegal    (resp_illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] phys  [0:63];   // memory as seen by the port
  logic [7:0]  ref_b [0:255];  // expected contents, byte addressed

  // observations from the last run_req
  logic        g_got, g_mval, g_stable, g_mis, g_ill, g_extra, g_ready_after;
  int          g_lat, g_busy;
  logic [31:0] g_rdata, g_maddr, g_mwdata;
  logic [3:0]  g_mwstrb;

  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic void set_word(input logic [31:0] a, input logic [31:0] v);
    phys[a[7:2]] = v;
    for (int i = 0; i < 4; i++) ref_b[{a[7:2], 2'(i)}] = v[8*i +: 8];
  endfunction

  function automatic logic exp_illegal(input logic st, input logic [2:0] f3);
    if (st) return f3 >= 3'd3;
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

  function automatic logic exp_mis(input logic st, input logic [2:0] f3, input logic [31:0] a);
    if (exp_illegal(st, f3)) return 1'b0;
    return (a % nbytes(f3)) != 0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    logic [7:0]  ba;
    v = 32'h0;
    for (int i = 0; i < nbytes(f3); i++) begin
      ba = a[7:0] + 8'(i);
      v  = v | (32'(ref_b[ba]) << (8 * i));
    end
    if (f3 == F3_B && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == F3_H && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  function automatic logic [3:0] exp_strb(input logic st, input logic [2:0] f3,
                                          input logic [31:0] a);
    int m;
    if (!st) return 4'h0;
    m = ((1 << nbytes(f3)) - 1) << (a % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] exp_lane(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nbytes(f3)) +: 8];
    return r;
  endfunction

  function automatic void ref_store(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] d);
    logic [7:0] ba;
    for (int i = 0; i < nbytes(f3); i++) begin
      ba        = a[7:0] + 8'(i);
      ref_b[ba] = d[8*i +: 8];
    end
  endfunction

  // Drives one request and acts as the memory; records what it saw.
  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input int nwait);
    int t;
    logic done;
    g_got = 0; g_mval = 0; g_stable = 1; g_lat = 0; g_busy = 0;
    g_rdata = 'x; g_mis = 'x; g_ill = 'x; g_extra = 'x; g_ready_after = 'x;
    t = 0;
    while (req_ready !== 1'b1 && t < 20) begin
      @(posedge clk); #1; t++;
    end
    dmem.s_ready = 1'($urandom_range(0, 1));  // ignored while idle
    dmem.s_rdata = $urandom;
    req_valid = 1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 0; req_wdata = $urandom;
    g_lat = 1;
    done  = 0;
    while (!done && g_lat < 40) begin
      dmem.s_ready = 1'b0;
      dmem.s_rdata = $urandom;
      if (dmem.m_valid === 1'b1) begin
        if (!g_mval) begin
          g_maddr = dmem.m_addr; g_mwdata = dmem.m_wdata; g_mwstrb = dmem.m_wstrb;
        end else if (dmem.m_addr !== g_maddr || dmem.m_wdata !== g_mwdata ||
                     dmem.m_wstrb !== g_mwstrb) begin
          g_stable = 0;
        end
        g_mval = 1;
        g_busy++;
        if (g_busy == nwait + 1) begin
          dmem.s_ready = 1'b1;
          dmem.s_rdata = phys[dmem.m_addr[7:2]];
          for (int i = 0; i < 4; i++)
            if (dmem.m_wstrb[i]) phys[dmem.m_addr[7:2]][8*i +: 8] = dmem.m_wdata[8*i +: 8];
        end
      end
      if (resp_valid === 1'b1) begin
        g_got = 1; g_rdata = resp_rdata; g_mis = resp_misaligned; g_ill = resp_illegal;
        done  = 1;
      end else begin
        @(posedge clk); #1;
        g_lat++;
      end
    end
    dmem.s_ready = 1'b1;  // RESP must ignore it too
    @(posedge clk); #1;
    dmem.s_ready = 1'b0;
    g_extra = resp_valid; g_ready_after = req_ready;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({req_ready, dmem.m_valid, resp_valid, resp_misaligned, resp_illegal} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 10000",
               {req_ready, dmem.m_valid, resp_valid, resp_misaligned, resp_illegal});
    end
    n_checks++;
    if ({dmem.m_addr, dmem.m_wdata, dmem.m_wstrb, resp_rdata} !== 100'h0) begin
      n_fail++;
      $display("FAIL reset_data: addr %h wdata %h wstrb %h rdata %h want all 0",
               dmem.m_addr, dmem.m_wdata, dmem.m_wstrb, resp_rdata);
    end
    rst = 0;
  endtask

  task automatic test_lw();
    set_word(32'h100, 32'hDEAD_BEEF);
    run_req(1'b0, F3_W, 32'h100, 32'h0, 0);
    n_checks++;
    if (g_maddr !== 32'h100 || g_mwstrb !== 4'h0) begin
      n_fail++;
      $display("FAIL lw_port: addr %h wstrb %b want 00000100 0000", g_maddr, g_mwstrb);
    end
    n_checks++;
    if (g_got !== 1'b1 || g_rdata !== 32'hDEAD_BEEF || g_lat !== 2) begin
      n_fail++;
      $display("FAIL lw_resp: got=%b rdata %h lat %0d want 1 deadbeef 2",
               g_got, g_rdata, g_lat);
    end
    n_checks++;
    if (g_extra !== 1'b0 || g_ready_after !== 1'b1) begin
      n_fail++;
      $display("FAIL lw_pulse: resp_valid %b ready %b after resp want 0 1",
               g_extra, g_ready_after);
    end
  endtask

  task automatic test_lb_lbu();
    set_word(32'h100, 32'h80FF_1234);
    run_req(1'b0, F3_B, 32'h103, 32'h0, 1);
    n_checks++;
    if (g_rdata !== 32'hFFFF_FF80 || g_lat !== 3) begin
      n_fail++;
      $display("FAIL lb: rdata %h lat %0d want ffffff80 3", g_rdata, g_lat);
    end
    run_req(1'b0, F3_BU, 32'h103, 32'h0, 0);
    n_checks++;
    if (g_rdata !== 32'h0000_0080) begin
      n_fail++;
      $display("FAIL lbu: rdata %h want 00000080", g_rdata);
    end
  endtask

  task automatic test_sh_wait();
    run_req(1'b1, F3_H, 32'h202, 32'h0000_ABCD, 3);
    ref_store(F3_H, 32'h202, 32'h0000_ABCD);
    n_checks++;
    if (g_mwstrb !== 4'b1100 || g_mwdata !== 32'hABCD_ABCD || g_maddr !== 32'h200) begin
      n_fail++;
      $display("FAIL sh_port: wstrb %b wdata %h addr %h want 1100 abcdabcd 00000200",
               g_mwstrb, g_mwdata, g_maddr);
    end
    n_checks++;
    if (g_busy !== 4 || g_stable !== 1'b1 || g_lat !== 5 || g_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL sh_timing: busy %0d stable %b lat %0d rdata %h want 4 1 5 0",
               g_busy, g_stable, g_lat, g_rdata);
    end
    run_req(1'b0, F3_HU, 32'h202, 32'h0, 0);
    n_checks++;
    if (g_rdata !== 32'h0000_ABCD) begin
      n_fail++;
      $display("FAIL sh_readback: rdata %h want 0000abcd", g_rdata);
    end
  endtask

  task automatic test_faults();
    run_req(1'b0, F3_W, 32'h101, 32'h0, 0);
    n_checks++;
    if ({g_got, g_mis, g_ill, g_mval} !== 4'b1100 || g_lat !== 1 || g_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL lw_misaligned: got/mis/ill/mval %b lat %0d rdata %h want 1100 1 0",
               {g_got, g_mis, g_ill, g_mval}, g_lat, g_rdata);
    end
    run_req(1'b1, 3'd4, 32'h100, 32'h1234, 0);
    n_checks++;
    if ({g_got, g_mis, g_ill, g_mval} !== 4'b1010 || g_lat !== 1) begin
      n_fail++;
      $display("FAIL st_illegal: got/mis/ill/mval %b lat %0d want 1010 1",
               {g_got, g_mis, g_ill, g_mval}, g_lat);
    end
    run_req(1'b0, 3'd3, 32'h101, 32'h0, 0);
    n_checks++;
    if ({g_mis, g_ill, g_mval} !== 3'b010) begin
      n_fail++;
      $display("FAIL illegal_precedence: mis/ill/mval %b want 010", {g_mis, g_ill, g_mval});
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    dmem.s_ready = 0;
    req_valid = 1; req_is_store = 0; req_funct3 = F3_W; req_addr = 32'h40; req_wdata = 0;
    @(posedge clk); #1;
    req_valid = 0;
    n_checks++;
    if (dmem.m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_busy: m_valid %b want 1", dmem.m_valid);
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    n_checks++;
    if (dmem.m_valid !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_idle: m_valid %b ready %b resp_valid %b want 0 1 0",
               dmem.m_valid, req_ready, resp_valid);
    end
    seen = 0;
    dmem.s_ready = 1;
    repeat (4) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b0 || dmem.m_valid !== 1'b0) seen = 1;
    end
    dmem.s_ready = 0;
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_quiet: activity after reset %b want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, ah, d;
    int w;
    for (int r = 0; r < 8; r++) begin
      a  = {$urandom_range(0, 63), 2'b00};
      ah = {$urandom_range(0, 127), 1'b0};
      d  = $urandom;
      w  = $urandom_range(0, 3);
      run_req(1'b1, F3_W, a, d, w);
      ref_store(F3_W, a, d);
      n_checks++;
      if (g_got !== 1'b1 || g_lat !== w + 2 || g_extra !== 1'b0 || g_ready_after !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_sw[%0d]: got %b lat %0d extra %b ready %b want 1 %0d 0 1",
                 r, g_got, g_lat, g_extra, g_ready_after, w + 2);
      end
      w = $urandom_range(0, 3);
      run_req(1'b0, F3_W, a, 32'h0, w);
      n_checks++;
      if (g_got !== 1'b1 || g_rdata !== d || g_lat !== w + 2 || g_extra !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_lw[%0d]: got %b rdata %h lat %0d want 1 %h %0d",
                 r, g_got, g_rdata, g_lat, d, w + 2);
      end
      w = $urandom_range(0, 3);
      run_req(1'b0, F3_HU, ah, 32'h0, w);
      n_checks++;
      if (g_got !== 1'b1 || g_rdata !== exp_load(F3_HU, ah) || g_lat !== w + 2) begin
        n_fail++;
        $display("FAIL b2b_lhu[%0d]: got %b rdata %h lat %0d want 1 %h %0d",
                 r, g_got, g_rdata, g_lat, exp_load(F3_HU, ah), w + 2);
      end
    end
  endtask

  task automatic test_random();
    logic st, ill, mis, fault;
    logic [2:0] f3;
    logic [31:0] a, d, er;
    int w;
    for (int r = 0; r < 60; r++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      d  = $urandom;
      w  = $urandom_range(0, 3);
      ill   = exp_illegal(st, f3);
      mis   = exp_mis(st, f3, a);
      fault = ill | mis;
      er    = (fault || st) ? 32'h0 : exp_load(f3, a);
      run_req(st, f3, a, d, w);
      if (!fault && st) ref_store(f3, a, d);
      n_checks++;
      if (g_got !== 1'b1 || g_rdata !== er || g_ill !== ill || g_mis !== mis ||
          g_mval !== !fault || g_lat !== (fault ? 1 : w + 2)) begin
        n_fail++;
        $display("FAIL rand_resp[%0d] st%0d f3=%0d a=%h: rdata %h ill %b mis %b mval %b lat %0d want %h %b %b %b %0d",
                 r, st, f3, a, g_rdata, g_ill, g_mis, g_mval, g_lat, er, ill, mis, !fault,
                 fault ? 1 : w + 2);
      end
      if (!fault) begin
        n_checks++;
        if (g_maddr !== {a[31:2], 2'b00} || g_mwstrb !== exp_strb(st, f3, a) ||
            (st && g_mwdata !== exp_lane(f3, d)) || g_stable !== 1'b1) begin
          n_fail++;
          $display("FAIL rand_port[%0d]: addr %h wstrb %b wdata %h stable %b want %h %b %h 1",
                   r, g_maddr, g_mwstrb, g_mwdata, g_stable, {a[31:2], 2'b00},
                   exp_strb(st, f3, a), exp_lane(f3, d));
        end
      end
    end
  endtask

  initial begin
    rst = 1; req_valid = 0; req_is_store = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    dmem.s_ready = 0; dmem.s_rdata = 0;
    for (int i = 0; i < 64; i++) set_word(32'(i * 4), $urandom);
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh_wait();
    test_faults();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
